// File: rtl/program_fetch_unit.sv
// rtl/program_fetch_unit.sv - program counter plus constant program ROM with registered fetch and self-halt
module program_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 9,
    parameter int DATA_W    = 16,
    // Replaces the HALT word with a NOP so the PC can be exercised across its full range.
    parameter bit HALT_FREE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [ADDR_W-1:0] address_out,
    output logic [INSTR_W-1:0] instruction,
    output logic [DATA_W-1:0] data_var,
    output logic              done
);

    localparam logic [2:0] OP_HALT = 3'b111;

    logic [INSTR_W-1:0] rom_instr;
    logic [DATA_W-1:0]  rom_data;

    always_comb begin
        rom_instr = '0;
        rom_data  = '0;
        case (address_out)
            ADDR_W'(0): begin
                rom_instr = INSTR_W'(9'b010_000_000);
                rom_data  = DATA_W'(16'h0005);
            end
            ADDR_W'(1): begin
                rom_instr = INSTR_W'(9'b010_001_000);
                rom_data  = DATA_W'(16'h0008);
            end
            ADDR_W'(2): rom_instr = INSTR_W'(9'b001_000_001);
            ADDR_W'(3): rom_instr = INSTR_W'(9'b011_001_000);
            ADDR_W'(4): rom_instr = INSTR_W'(9'b101_000_000);
            ADDR_W'(5): rom_instr = HALT_FREE ? '0 : INSTR_W'(9'b111_000_000);
            default: begin
                rom_instr = '0;
                rom_data  = '0;
            end
        endcase
    end

    assign done = (instruction[INSTR_W-1 -: 3] == OP_HALT);

    // Once HALT is registered everything freezes; only reset leaves this state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address_out <= '0;
            instruction <= '0;
            data_var    <= '0;
        end else if (!done) begin
            instruction <= rom_instr;
            data_var    <= rom_data;
            if (step) begin
                address_out <= address_out + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_program_fetch_unit.sv
// tb/tb_program_fetch_unit.sv - directed and randomized checks of program_fetch_unit against a reference model
module tb_program_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, step, rst2, step2;
    logic [7:0]  address_out, address_out2;
    logic [8:0]  instruction, instruction2;
    logic [15:0] data_var, data_var2;
    logic        done, done2;

    program_fetch_unit dut (
        .clk(clk), .rst(rst), .step(step),
        .address_out(address_out), .instruction(instruction),
        .data_var(data_var), .done(done)
    );

    program_fetch_unit #(.HALT_FREE(1'b1)) dut_nh (
        .clk(clk), .rst(rst2), .step(step2),
        .address_out(address_out2), .instruction(instruction2),
        .data_var(data_var2), .done(done2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0]  rom_i [256];
    logic [15:0] rom_d [256];
    logic [8:0]  rom_nh_i [256];

    int          m_pc, n_pc;
    logic [8:0]  m_ins, n_ins;
    logic [15:0] m_dat, n_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: fetch the word at the current PC, advance PC by step modulo 256, freeze on HALT.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_pc = 0; m_ins = 0; m_dat = 0;
        end else if (m_ins[8:6] != 3'b111) begin
            m_ins = rom_i[m_pc];
            m_dat = rom_d[m_pc];
            if (step) m_pc = (m_pc + 1) % 256;
        end
        if (!rst2) begin
            n_pc = 0; n_ins = 0; n_dat = 0;
        end else if (n_ins[8:6] != 3'b111) begin
            n_ins = rom_nh_i[n_pc];
            n_dat = rom_d[n_pc];
            if (step2) n_pc = (n_pc + 1) % 256;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"}, 32'(address_out), 32'(m_pc));
        chk({tag, "_ins"}, 32'(instruction), 32'(m_ins));
        chk({tag, "_dat"}, 32'(data_var), 32'(m_dat));
        chk({tag, "_done"}, 32'(done), 32'(m_ins[8:6] == 3'b111));
    endtask

    task automatic check_nh(input string tag);
        chk({tag, "_pc"}, 32'(address_out2), 32'(n_pc));
        chk({tag, "_ins"}, 32'(instruction2), 32'(n_ins));
        chk({tag, "_dat"}, 32'(data_var2), 32'(n_dat));
    endtask

    // Drops reset between edges and checks that outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        m_pc = 0; m_ins = 0; m_dat = 0;
        #1;
        chk({tag, "_pc0"}, 32'(address_out), 32'h0);
        chk({tag, "_ins0"}, 32'(instruction), 32'h0);
        chk({tag, "_dat0"}, 32'(data_var), 32'h0);
        chk({tag, "_done0"}, 32'(done), 32'h0);
        tick();
        rst = 1'b1;
    endtask

    int          exp_pc  [6] = '{1, 2, 3, 4, 5, 6};
    logic [8:0]  exp_ins [6] = '{9'h080, 9'h088, 9'h041, 9'h0C8, 9'h140, 9'h1C0};
    logic [15:0] exp_dat [6] = '{16'h0005, 16'h0008, 16'h0, 16'h0, 16'h0, 16'h0};
    logic        gate_step [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          gate_pc   [4] = '{1, 1, 1, 2};
    logic [8:0]  gate_ins  [4] = '{9'h080, 9'h088, 9'h088, 9'h088};

    initial begin
        for (int a = 0; a < 256; a++) begin
            rom_i[a] = '0; rom_d[a] = '0;
        end
        rom_i[0] = 9'b010_000_000; rom_d[0] = 16'h0005;
        rom_i[1] = 9'b010_001_000; rom_d[1] = 16'h0008;
        rom_i[2] = 9'b001_000_001;
        rom_i[3] = 9'b011_001_000;
        rom_i[4] = 9'b101_000_000;
        rom_i[5] = 9'b111_000_000;
        rom_nh_i = rom_i;
        rom_nh_i[5] = 9'h000;

        rst = 1'b0; step = 1'b0; rst2 = 1'b0; step2 = 1'b0;
        m_pc = 0; m_ins = 0; m_dat = 0;
        n_pc = 0; n_ins = 0; n_dat = 0;

        for (int i = 0; i < 3; i++) tick();
        check_all("reset");
        chk("reset_pc", 32'(address_out), 32'h0);
        chk("reset_ins", 32'(instruction), 32'h0);

        rst = 1'b1;
        tick();
        check_all("release");
        chk("release_pc", 32'(address_out), 32'h0);
        chk("release_ins", 32'(instruction), 32'h080);
        chk("release_dat", 32'(data_var), 32'h0005);

        step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("run");
            chk($sformatf("run%0d_pc", i + 1), 32'(address_out), 32'(exp_pc[i]));
            chk($sformatf("run%0d_ins", i + 1), 32'(instruction), 32'(exp_ins[i]));
            chk($sformatf("run%0d_dat", i + 1), 32'(data_var), 32'(exp_dat[i]));
        end
        chk("run_done", 32'(done), 32'h1);

        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("halt");
        end
        chk("halt_pc", 32'(address_out), 32'h6);
        chk("halt_ins", 32'(instruction), 32'h1C0);
        chk("halt_done", 32'(done), 32'h1);

        async_reset("halt_rst");
        for (int i = 0; i < 4; i++) begin
            step = gate_step[i];
            tick();
            check_all("gate");
            chk($sformatf("gate%0d_pc", i), 32'(address_out), 32'(gate_pc[i]));
            chk($sformatf("gate%0d_ins", i), 32'(instruction), 32'(gate_ins[i]));
        end

        step = 1'b1;
        tick();
        chk("midrun_pc3", 32'(address_out), 32'h3);
        async_reset("midrun_rst");
        tick();
        check_all("restart");
        chk("restart_pc", 32'(address_out), 32'h1);
        chk("restart_ins", 32'(instruction), 32'h080);

        for (int i = 0; i < 300; i++) begin
            step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) async_reset("rand_rst");
            tick();
            check_all("rand");
        end

        rst2 = 1'b1;
        step2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            check_nh("nh");
        end
        chk("wrap_pc", 32'(address_out2), 32'h0);
        chk("wrap_ins", 32'(instruction2), 32'h000);
        chk("wrap_dat", 32'(data_var2), 32'h0);
        chk("wrap_done", 32'(done2), 32'h0);
        tick();
        check_nh("nh_after");
        chk("wrap_next_ins", 32'(instruction2), 32'h080);
        chk("wrap_next_pc", 32'(address_out2), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
